// File: rtl/elastic_pipe_buf.sv
// Elastic valid/ready buffer of DEPTH entries with synchronous flush and occupancy outputs.
// Optional performance counters are enabled by defining ELASTIC_PIPE_BUF_PERF_EN.
module elastic_pipe_buf #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
`ifdef ELASTIC_PIPE_BUF_PERF_EN
  ,
  output logic [31:0]      perf_bp_cycles_o,
  output logic [31:0]      perf_starve_cycles_o
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0]  LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq, deq;

  // Ready and valid come from registered count only, so no combinational path crosses the stage.
  assign in_ready_o  = (count_q < DepthCnt);
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == DepthCnt);
  assign empty_o     = (count_q == '0);

  assign enq = in_valid_i && in_ready_o && !flush_i;
  assign deq = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (enq && !rst) mem_q[wr_ptr_q] <= in_data_i;
  end

`ifdef ELASTIC_PIPE_BUF_PERF_EN
  logic [31:0] bp_q, starve_q;

  // Saturating counters; flush deliberately leaves them intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_q     <= '0;
      starve_q <= '0;
    end else begin
      if (out_valid_o && !out_ready_i && (bp_q != '1)) bp_q <= bp_q + 1'b1;
      if (in_ready_o && !in_valid_i && empty_o && (starve_q != '1)) starve_q <= starve_q + 1'b1;
    end
  end

  assign perf_bp_cycles_o     = bp_q;
  assign perf_starve_cycles_o = starve_q;
`endif

`ifndef SYNTHESIS
  a_hold_valid : assert property (@(posedge clk) disable iff (rst)
      (in_valid_i && !in_ready_o && !flush_i) |=> (in_valid_i || flush_i));
  a_count_range : assert property (@(posedge clk) disable iff (rst) count_q <= DepthCnt);
`endif

endmodule

// File: tb/tb_elastic_pipe_buf.sv
// Bench for elastic_pipe_buf: four instances (DEPTH 1..4) checked every cycle against
// queue-based reference models under directed and randomized stimulus.
module tb_elastic_pipe_buf;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        flush     [N];
  logic [31:0] in_data   [N];
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic [31:0] out_data  [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [2:0]  count     [N];
  logic        full      [N];
  logic        empty     [N];
`ifdef ELASTIC_PIPE_BUF_PERF_EN
  logic [31:0] perf_bp   [N];
  logic [31:0] perf_st   [N];
`endif

  for (genvar g = 0; g < N; g++) begin : g_dut
    elastic_pipe_buf #(
      .WIDTH(32),
      .DEPTH(g + 1),
      .CNT_W(3)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush[g]),
      .in_data_i  (in_data[g]),
      .in_valid_i (in_valid[g]),
      .in_ready_o (in_ready[g]),
      .out_data_o (out_data[g]),
      .out_valid_o(out_valid[g]),
      .out_ready_i(out_ready[g]),
      .count_o    (count[g]),
      .full_o     (full[g]),
      .empty_o    (empty[g])
`ifdef ELASTIC_PIPE_BUF_PERF_EN
      ,
      .perf_bp_cycles_o    (perf_bp[g]),
      .perf_starve_cycles_o(perf_st[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain FIFO queue per instance plus perf tallies.
  logic [31:0] mq [N][$];
  int unsigned mbp [N];
  int unsigned mst [N];
  logic        acc [N];
  logic        pend [N];
  int          vectors = 0;
  int          errors  = 0;

  task automatic chk(input int d, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL d%0d %s: observed %h expected %h", d + 1, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      int sz = mq[i].size();
      chk(i, "count", 32'(count[i]), 32'(sz));
      chk(i, "out_valid", 32'(out_valid[i]), 32'(sz != 0));
      chk(i, "in_ready", 32'(in_ready[i]), 32'(sz < i + 1));
      chk(i, "full", 32'(full[i]), 32'(sz == i + 1));
      chk(i, "empty", 32'(empty[i]), 32'(sz == 0));
      if (sz > 0) chk(i, "out_data", out_data[i], mq[i][0]);
`ifdef ELASTIC_PIPE_BUF_PERF_EN
      chk(i, "perf_bp", perf_bp[i], mbp[i]);
      chk(i, "perf_starve", perf_st[i], mst[i]);
`endif
    end
  endtask

  // One clock: model follows the edge using the inputs held across it, then check at negedge.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      int  sz   = mq[i].size();
      bit  take = out_ready[i] && (sz > 0);
      acc[i] = 1'b0;
      if (rst) begin
        mq[i].delete();
        mbp[i] = 0;
        mst[i] = 0;
      end else begin
        if (sz > 0 && !out_ready[i]) mbp[i]++;
        if (sz == 0 && !in_valid[i]) mst[i]++;
        if (flush[i]) begin
          mq[i].delete();
        end else begin
          acc[i] = in_valid[i] && (sz < i + 1);
          if (take) void'(mq[i].pop_front());
          if (acc[i]) mq[i].push_back(in_data[i]);
        end
      end
      pend[i] = in_valid[i] && !acc[i] && !flush[i] && !rst;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] dat, input logic r,
                       input logic f);
    in_valid[d]  = v;
    in_data[d]   = dat;
    out_ready[d] = r;
    flush[d]     = f;
  endtask

  initial begin
    int nacc;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      drive(i, 1'b0, 32'h0, 1'b0, 1'b0);
      mbp[i] = 0;
      mst[i] = 0;
      pend[i] = 1'b0;
    end
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // DEPTH=2 streaming 0x11..0x18 with downstream always ready.
    for (int k = 0; k < 9; k++) begin
      drive(1, k < 8, 32'h11 + k, 1'b1, 1'b0);
      cycle();
    end
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle();

    // DEPTH=3 fill to full, drain in order, then refill across the wrap.
    drive(2, 1'b1, 32'hA, 1'b0, 1'b0); cycle();
    drive(2, 1'b1, 32'hB, 1'b0, 1'b0); cycle();
    drive(2, 1'b1, 32'hC, 1'b0, 1'b0); cycle();
    drive(2, 1'b0, 32'h0, 1'b0, 1'b0); cycle();
    chk(2, "full_after_fill", 32'(full[2]), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(2, 1'b0, 32'h0, 1'b1, 1'b0);
      cycle();
    end
    chk(2, "empty_after_drain", 32'(empty[2]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(2, k < 2, 32'hD + k, k > 0, 1'b0);
      cycle();
    end
    drive(2, 1'b0, 32'h0, 1'b0, 1'b0);

    // DEPTH=1: continuous valid/ready, payload advances only on acceptance.
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      drive(0, nacc < 4, 32'(1 + nacc), 1'b1, 1'b0);
      cycle();
      if (acc[0]) nacc++;
    end
    chk(0, "d1_accepted", 32'(nacc), 32'd4);
    chk(0, "d1_drained", 32'(empty[0]), 32'd1);
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);

    // DEPTH=4 flush with a concurrent enqueue and dequeue.
    drive(3, 1'b1, 32'h1, 1'b0, 1'b0); cycle();
    drive(3, 1'b1, 32'h2, 1'b0, 1'b0); cycle();
    drive(3, 1'b1, 32'h3, 1'b1, 1'b1); cycle();
    chk(3, "flush_count", 32'(count[3]), 32'd0);
    drive(3, 1'b1, 32'h4, 1'b1, 1'b0); cycle();
    chk(3, "post_flush_head", out_data[3], 32'h4);
    drive(3, 1'b0, 32'h0, 1'b1, 1'b0); cycle();
    drive(3, 1'b0, 32'h0, 1'b0, 1'b0); cycle();

    // Reset mid-stream on DEPTH=2 holding two entries.
    drive(1, 1'b1, 32'h31, 1'b0, 1'b0); cycle();
    drive(1, 1'b1, 32'h32, 1'b0, 1'b0); cycle();
    drive(1, 1'b1, 32'h77, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk(1, "rst_in_ready", 32'(in_ready[1]), 32'd1);
    drive(1, 1'b1, 32'h55, 1'b1, 1'b0); cycle();
    chk(1, "rst_then_push", out_data[1], 32'h55);
    drive(1, 1'b0, 32'h0, 1'b1, 1'b0); cycle();
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0); cycle();

`ifdef ELASTIC_PIPE_BUF_PERF_EN
    // Backpressure counter: 10 stalled cycles, survives flush, cleared by reset.
    rst = 1'b1; cycle(); rst = 1'b0;
    drive(2, 1'b1, 32'h66, 1'b0, 1'b0); cycle();
    drive(2, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (10) cycle();
    chk(2, "perf_bp_10", perf_bp[2], 32'd10);
    drive(2, 1'b0, 32'h0, 1'b1, 1'b1); cycle();
    chk(2, "perf_bp_flush", perf_bp[2], 32'd10);
    drive(2, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk(2, "perf_bp_rst", perf_bp[2], 32'd0);
`endif

    // Randomized traffic on all instances; a stalled payload is held until accepted.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          in_valid[i] = ($urandom_range(0, 3) != 0);
          in_data[i]  = $urandom;
        end
        out_ready[i] = ($urandom_range(0, 3) != 0);
        flush[i]     = ($urandom_range(0, 31) == 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_buf.md
Name: elastic_pipe_buf

Overview:
- Parametrised elastic buffer between two valid/ready pipeline stages (fetch->decode, decode->rename, rename->issue). It generalises the single-entry, enable-gated stage register to DEPTH entries of WIDTH bits.
- Adds a synchronous flush for mispredict/exception recovery, occupancy reporting, and registered ready so no combinational ready path crosses the stage.

Parameters:
- WIDTH, 64: payload width in bits; must be >= 1.
- DEPTH, 2: number of entries; must be >= 1. Need not be a power of two.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  discard all held entries this cycle.
- in_data_i  in  WIDTH  payload from the upstream stage.
- in_valid_i  in  1  upstream payload is valid.
- in_ready_o  out  1  buffer accepts a payload this cycle.
- out_data_o  out  WIDTH  payload at the head of the buffer.
- out_valid_o  out  1  head entry is valid.
- out_ready_i  in  1  downstream consumes the head this cycle.
- count_o  out  CNT_W  number of valid entries held.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage: circular array of DEPTH entries with rd_ptr and wr_ptr in 0..DEPTH-1. Each pointer wraps from DEPTH-1 to 0 explicitly; no power-of-two masking.
- Enqueue condition: in_valid_i && in_ready_o && !flush_i.
- Dequeue condition: out_valid_o && out_ready_i && !flush_i.
- in_ready_o = (count < DEPTH). It is a function of registered state only and never depends on out_ready_i.
- out_valid_o = (count != 0). out_data_o = mem[rd_ptr], driven combinationally from the registered array.
- Latency: a payload enqueued into an empty buffer at cycle N appears on out_valid_o at cycle N+1. There is no same-cycle bypass.
- Throughput:
  - DEPTH >= 2: one transfer per cycle sustained under continuous in_valid_i and out_ready_i.
  - DEPTH = 1: at most one transfer every 2 cycles, because full blocks enqueue in the dequeue cycle. This is intentional.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. With count == 1, the new entry becomes head on the next cycle.
- Full: in_ready_o = 0. Upstream must hold in_data_i and in_valid_i stable until accepted.
- Empty: out_valid_o = 0. out_data_o is don't-care; the bench must not check it.
- Flush (flush_i = 1), next-cycle state:
  - count = 0, rd_ptr = wr_ptr = 0.
  - Any enqueue or dequeue presented in the same cycle is ignored: no entry written, no handshake completed. Upstream must treat its payload as killed.
  - in_ready_o and out_valid_o still reflect the pre-flush state during the flush cycle.
- Reset (rst = 1, synchronous): same effect as flush.
  - Outputs after the reset edge: out_valid_o = 0, in_ready_o = 1, count_o = 0, empty_o = 1, full_o = 0.
  - Payload RAM is not reset.
  - Reset asserted mid-stream discards all entries on that edge.
- Reset has priority over flush; flush has priority over enqueue and dequeue.
- Protocol checks in simulation only:
  - Assert on in_valid_i dropping while in_ready_o == 0, unless flush_i is high.
  - Assert count <= DEPTH every cycle.

Optional Feature:
- Macro: ELASTIC_PIPE_BUF_PERF_EN.
- Defined: adds outputs perf_bp_cycles_o[31:0] and perf_starve_cycles_o[31:0].
  - perf_bp_cycles_o increments each cycle with out_valid_o && !out_ready_i (downstream backpressure).
  - perf_starve_cycles_o increments each cycle with in_ready_o && !in_valid_i && empty_o (upstream bubble).
  - Both saturate at 32'hFFFFFFFF, clear on rst, and are not cleared by flush_i.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. DEPTH=2, WIDTH=32: stream 0x11..0x18 with out_ready_i=1 constantly -> after 1-cycle latency, 8 consecutive outputs 0x11..0x18 in order, one per cycle, in_ready_o stays 1.
2. DEPTH=3: push 0xA,0xB,0xC with out_ready_i=0 -> count_o = 3, full_o = 1, in_ready_o = 0. Then raise out_ready_i for 3 cycles -> 0xA,0xB,0xC in order, empty_o = 1 and rd_ptr back at 0 (wrap check).
3. DEPTH=1: continuous in_valid_i and out_ready_i, data 1..4 -> out_valid_o pattern 0,1,0,1,...; all 4 delivered in order within 8 cycles.
4. DEPTH=4 holding 0x1,0x2: assert flush_i together with in_valid_i (0x3) and out_ready_i -> no handshake completes. Next cycle count_o = 0, out_valid_o = 0. Then push 0x4 -> only 0x4 emerges.
5. Stream in progress with count_o = 2: assert rst for one cycle -> count_o = 0, out_valid_o = 0, in_ready_o = 1 on the next edge; a subsequent push of 0x55 is received 1 cycle later.
6. ELASTIC_PIPE_BUF_PERF_EN defined: hold out_valid_o with out_ready_i=0 for 10 cycles -> perf_bp_cycles_o = 10. Then flush -> value unchanged. Then rst -> 0.
